// File: rtl/spw_rate_pkg.sv
// Shared types and defaults for the SpaceWire TX rate sequencer.
package spw_rate_pkg;

    localparam int DEF_DIV_W    = 7;
    localparam int DEF_INIT_DIV = 9;
    localparam int DEF_MIN_DIV  = 1;

    typedef logic [DEF_DIV_W-1:0] div_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SETTLE,
        ST_RAMP,
        ST_RUN
    } rate_state_e;

endpackage

// File: rtl/spw_tx_rate_ctrl_tick.sv
// Bit-period counter: one registered tx_bit_en strobe every div+1 cycles.
module spw_bit_tick #(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,       // divider in effect during the next cycle
    input  logic             clear,
    output logic             tx_bit_en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;

    // The strobe itself marks the wrap, so a divider change at the boundary
    // takes effect from position 0 of the following period.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        if (tx_bit_en || cnt >= div)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            tx_bit_en <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            tx_bit_en <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            tx_bit_en <= (cnt_nxt == div);
        end
    end

endmodule

// File: rtl/spw_tx_rate_ctrl.sv
// TX bit-rate sequencer: fixed init rate until the link runs, then settle and
// ramp one divider step at a time to the host target, on bit boundaries.
module spw_tx_rate_ctrl
    import spw_rate_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int INIT_DIV    = DEF_INIT_DIV,
    parameter int MIN_DIV     = DEF_MIN_DIV,
    parameter int SETTLE_BITS = 64,
    parameter int STEP_BITS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             link_running,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             tx_bit_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             ramp_busy,
    output logic             at_target
);

    localparam int SW = $clog2(SETTLE_BITS + 1);
    localparam int PW = $clog2(STEP_BITS + 1);

    localparam logic [DIV_W-1:0] INIT_V      = DIV_W'(INIT_DIV);
    localparam logic [DIV_W-1:0] MIN_V       = DIV_W'(MIN_DIV);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_BITS - 1);
    localparam logic [PW-1:0]    STEP_LAST   = PW'(STEP_BITS - 1);

    rate_state_e      state, state_nxt;
    logic [DIV_W-1:0] tgt, stepped, div_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [PW-1:0]    step_cnt, step_nxt;
    logic             drop;

    assign tgt  = (cfg_div < MIN_V) ? MIN_V : cfg_div;
    assign drop = (state != ST_INIT) && !link_running;

    // One step toward tgt; tgt is always in range so this cannot wrap.
    assign stepped = (cur_div < tgt) ? cur_div + 1'b1 :
                     (cur_div > tgt) ? cur_div - 1'b1 : cur_div;

    always_comb begin
        state_nxt  = state;
        div_nxt    = cur_div;
        settle_nxt = settle_cnt;
        step_nxt   = step_cnt;
        if (drop) begin
            state_nxt  = ST_INIT;
            div_nxt    = INIT_V;
            settle_nxt = '0;
            step_nxt   = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    div_nxt = INIT_V;
                    if (link_running) begin
                        state_nxt  = ST_SETTLE;
                        settle_nxt = '0;
                        step_nxt   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (tx_bit_en) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_nxt = '0;
                            step_nxt   = '0;
                            div_nxt    = stepped;
                            state_nxt  = (stepped == tgt) ? ST_RUN : ST_RAMP;
                        end else begin
                            settle_nxt = settle_cnt + 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (tx_bit_en) begin
                        if (step_cnt == STEP_LAST) begin
                            step_nxt = '0;
                            div_nxt  = stepped;
                            if (stepped == tgt)
                                state_nxt = ST_RUN;
                        end else begin
                            step_nxt = step_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cur_div != tgt) begin
                        state_nxt = ST_RAMP;
                        step_nxt  = '0;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            cur_div    <= INIT_V;
            settle_cnt <= '0;
            step_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            cur_div    <= div_nxt;
            settle_cnt <= settle_nxt;
            step_cnt   <= step_nxt;
        end
    end

    assign ramp_busy = (state == ST_SETTLE) || (state == ST_RAMP);
    assign at_target = (state == ST_RUN) && (cur_div == tgt);

    spw_bit_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .div      (div_nxt),
        .clear    (drop),
        .tx_bit_en(tx_bit_en)
    );

endmodule
